data_mem_arbiter: RTL and testbench

//   Shares the single-port word-addressed data memory between two requesters:

---
 rtl/data_mem_arbiter.sv | 101 ++++++++++
 tb/tb_data_mem_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin, burst-capped arbiter sharing one data memory port between two requesters
module data_mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          last_owner;
  logic [CW-1:0] burst_cnt;
  logic          keep_owner;

  // burst_cnt==0 means nobody has owned the memory yet, so the tie goes to
  // the port opposite last_owner (port 0 after reset).
  always_comb begin
    keep_owner = (burst_cnt != '0) && (burst_cnt < CNT_MAX);
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    if (rst_n) begin
      if (m0_req && m1_req) begin
        m0_gnt = keep_owner ? ~last_owner : last_owner;
        m1_gnt = keep_owner ?  last_owner : ~last_owner;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_read  = ~m0_we;
      mem_write = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_read  = ~m1_we;
      mem_write = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= 1'b1;
      burst_cnt  <= '0;
    end else if (m0_gnt || m1_gnt) begin
      if (m1_gnt == last_owner) begin
        if (burst_cnt < CNT_MAX) burst_cnt <= burst_cnt + CNT_ONE;
      end else begin
        last_owner <= m1_gnt;
        burst_cnt  <= CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rdata  <= '0;
      m0_rvalid <= 1'b0;
      m1_rdata  <= '0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      if (m0_gnt && !m0_we) m0_rdata <= mem_rdata;
      if (m1_gnt && !m1_we) m1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter with a 32-word memory model
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:31];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[6:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[6:2]] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic eg0, input logic eg1, input logic [31:0] ed, input string tag);
    logic [31:0] exp_addr;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    exp_addr = eg0 ? a0 : (eg1 ? a1 : 32'h0);
    @(negedge clk);
    check({tag, " m0_gnt"}, {31'b0, m0_gnt}, {31'b0, eg0});
    check({tag, " m1_gnt"}, {31'b0, m1_gnt}, {31'b0, eg1});
    check({tag, " mem_read"}, {31'b0, mem_read}, {31'b0, (eg0 & ~w0) | (eg1 & ~w1)});
    check({tag, " mem_write"}, {31'b0, mem_write}, {31'b0, (eg0 & w0) | (eg1 & w1)});
    check({tag, " mem_addr"}, mem_addr, exp_addr);
    if (eg0 && !w0) q0.push_back(ed);
    if (eg1 && !w1) q1.push_back(ed);
    @(posedge clk); #1;
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic do_reset();
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever a read-valid pulse appears.
  initial begin
    forever begin
      @(negedge clk);
      if (m0_rvalid) begin
        if (q0.size() == 0) check("m0 unexpected rvalid", 32'd1, 32'd0);
        else check("m0_rdata", m0_rdata, q0.pop_front());
      end
      if (m1_rvalid) begin
        if (q1.size() == 0) check("m1 unexpected rvalid", 32'd1, 32'd0);
        else check("m1_rdata", m1_rdata, q1.pop_front());
      end
    end
  end

  logic [11:0] pat;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    rst_n = 1'b0;
    #2;
    check("reset m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
    check("reset m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    check("reset m0_rdata", m0_rdata, 32'd0);
    check("reset m1_rdata", m1_rdata, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Tie right after reset goes to port 0, then port 1 once port 0 drops.
    step(1, 0, 32'h08, 0, 1, 0, 32'h0C, 0, 1, 0, 32'h1000_0002, "tie c0");
    step(0, 0, 32'h08, 0, 1, 0, 32'h0C, 0, 0, 1, 32'h1000_0003, "tie c1");
    idle("tie idle");
    do_reset();

    // Both requesting for 12 cycles: 4 to port 0, 4 to port 1, 4 to port 0.
    pat = 12'b0000_1111_0000;
    for (int i = 0; i < 12; i++) begin
      if (pat[11-i])
        step(1, 0, 32'h00, 0, 1, 0, 32'h04, 0, 0, 1, 32'h1000_0001, $sformatf("burst c%0d", i));
      else
        step(1, 0, 32'h00, 0, 1, 0, 32'h04, 0, 1, 0, 32'h1000_0000, $sformatf("burst c%0d", i));
    end

    step(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0, 0, "p0 write");
    step(1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, "p0 read");
    idle("idle a");

    step(0, 0, 0, 0, 1, 1, 32'h20, 32'h55, 0, 1, 0, "m1 write");
    step(1, 0, 32'h20, 0, 0, 0, 0, 0, 1, 0, 32'h55, "m0 race read");
    idle("idle b");
    check("m1_rdata hold", m1_rdata, 32'h1000_0001);
    check("m0_rdata hold", m0_rdata, 32'h55);

    // Reset asserted mid-cycle during a write grant.
    m0_req = 1; m0_we = 1; m0_addr = 32'h30; m0_wdata = 32'h0000_0BAD;
    #1 check("pre-reset mem_write", {31'b0, mem_write}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("in-reset mem_write", {31'b0, mem_write}, 32'd0);
    check("in-reset m0_gnt", {31'b0, m0_gnt}, 32'd0);
    check("in-reset m0_rdata", m0_rdata, 32'd0);
    check("in-reset m1_rdata", m1_rdata, 32'd0);
    check("in-reset m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
    @(posedge clk); #1;
    check("no write during reset", mem[12], 32'h1000_000C);
    m0_req = 0; m0_we = 0;
    rst_n = 1'b1;

    // Read granted, then reset lands before the capturing edge.
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    @(negedge clk);
    check("mid-read m0_gnt", {31'b0, m0_gnt}, 32'd1);
    #2 rst_n = 1'b0;
    m0_req = 0;
    @(posedge clk); #1;
    check("mid-read rvalid in reset", {31'b0, m0_rvalid}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post-release rvalid c%0d", i), {31'b0, m0_rvalid}, 32'd0);
    end

    check("pending m0 reads", q0.size(), 32'd0);
    check("pending m1 reads", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
